// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
// Shared JTAG scan-chain definitions: the default instruction register width,
// instruction opcodes, the IR capture pattern and the data-register select
// type used inside the scan chain.
// -----------------------------------------------------------------------------
package jtag_pkg;

    // Default instruction register width.
    localparam int JTAG_IR_WIDTH = 5;

    // Instruction opcodes. Any opcode not listed here selects BYPASS.
    localparam logic [4:0] JTAG_IR_IDCODE = 5'h01;
    localparam logic [4:0] JTAG_IR_USER   = 5'h10;
    localparam logic [4:0] JTAG_IR_BYPASS = 5'h1F;

    // Value loaded into the IR shift register on capture. The fixed "01" in the
    // two LSBs lets a host find IR boundaries on a multi-device chain.
    localparam logic [1:0] JTAG_IR_CAPTURE = 2'b01;

    // Which data register sits between TDI and TDO.
    typedef enum logic [1:0] {
        DR_SEL_BYPASS = 2'd0,
        DR_SEL_IDCODE = 2'd1,
        DR_SEL_USER   = 2'd2
    } dr_sel_e;

endpackage : jtag_pkg

// File: rtl/jtag_scan_chain_if.sv
// -----------------------------------------------------------------------------
// jtag_scan_chain_if
// Bundle between the TAP controller / debug logic (master) and the scan chain
// (slave).
//   tdi, tap_reset, shift/capture/update strobes : master -> slave
//   user_capture_data                            : master -> slave
//   tdo, tdo_en, ir_active                       : slave  -> master
//   user_update_data, user_update_valid          : slave  -> master
// -----------------------------------------------------------------------------
interface jtag_scan_chain_if #(
    parameter int IR_WIDTH      = 5,
    parameter int USER_DR_WIDTH = 32
);
    logic                     tdi;
    logic                     shift_dr;
    logic                     shift_ir;
    logic                     capture_dr;
    logic                     capture_ir;
    logic                     update_dr;
    logic                     update_ir;
    logic                     tap_reset;
    logic                     tdo;
    logic                     tdo_en;
    logic [IR_WIDTH-1:0]      ir_active;
    logic [USER_DR_WIDTH-1:0] user_capture_data;
    logic [USER_DR_WIDTH-1:0] user_update_data;
    logic                     user_update_valid;

    modport master (
        output tdi, shift_dr, shift_ir, capture_dr, capture_ir,
               update_dr, update_ir, tap_reset, user_capture_data,
        input  tdo, tdo_en, ir_active, user_update_data, user_update_valid
    );

    modport slave (
        input  tdi, shift_dr, shift_ir, capture_dr, capture_ir,
               update_dr, update_ir, tap_reset, user_capture_data,
        output tdo, tdo_en, ir_active, user_update_data, user_update_valid
    );
endinterface : jtag_scan_chain_if

// File: rtl/jtag_shift_reg.sv
// -----------------------------------------------------------------------------
// jtag_shift_reg
// Generic LSB-first shift register for the JTAG scan chain.
//   clk, rst_n   : clock, asynchronous active-low reset (clears to 0)
//   clr_i        : synchronous clear, highest priority
//   load_i       : parallel load of load_data_i
//   shift_i      : shift right by one, sin_i enters at the MSB
//   data_o       : register contents (bit 0 is the serial output)
// Priority: clear > load > shift.
// -----------------------------------------------------------------------------
module jtag_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] shifted;

    // Right-shift network: each bit takes its upper neighbour, the MSB takes
    // the serial input.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (gi == WIDTH - 1) begin : g_msb
            assign shifted[gi] = sin_i;
        end else begin : g_mid
            assign shifted[gi] = data_q[gi+1];
        end
    end

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule : jtag_shift_reg

// File: rtl/jtag_scan_chain.sv
// -----------------------------------------------------------------------------
// jtag_scan_chain
// Instruction register plus BYPASS / IDCODE / USER data registers and the TDO
// multiplexer, driven by the TAP controller strobes.
//   clk, rst_n : TCK-domain clock, asynchronous active-low reset
//   bus        : jtag_scan_chain_if slave port (strobes, tdi/tdo, ir_active,
//                USER parallel capture/update data)
// -----------------------------------------------------------------------------
module jtag_scan_chain
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH      = JTAG_IR_WIDTH,
    parameter logic [31:0] IDCODE_VALUE  = 32'h1DEAD3FF,
    parameter int          USER_DR_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    jtag_scan_chain_if.slave  bus
);

    localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(JTAG_IR_IDCODE);
    localparam logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(JTAG_IR_USER);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(JTAG_IR_CAPTURE);

    // -------------------------------------------------------------------------
    // Strobe arbitration. The TAP never asserts two strobes together, but if it
    // does, IR beats DR and within a path capture > shift > update.
    // -------------------------------------------------------------------------
    logic ir_any;
    logic ir_cap;
    logic ir_shift;
    logic ir_upd;
    logic dr_cap;
    logic dr_shift;
    logic dr_upd;

    assign ir_any   = bus.capture_ir | bus.shift_ir | bus.update_ir;
    assign ir_cap   = bus.capture_ir;
    assign ir_shift = bus.shift_ir & ~bus.capture_ir;
    assign ir_upd   = bus.update_ir & ~bus.capture_ir & ~bus.shift_ir;
    assign dr_cap   = bus.capture_dr & ~ir_any;
    assign dr_shift = bus.shift_dr & ~ir_any & ~bus.capture_dr;
    assign dr_upd   = bus.update_dr & ~ir_any & ~bus.capture_dr & ~bus.shift_dr;

    // -------------------------------------------------------------------------
    // Active instruction and data register select. ir_active only moves on
    // update_ir or reset, so a DR scan can never switch register mid-scan.
    // -------------------------------------------------------------------------
    logic [IR_WIDTH-1:0] ir_active_q;
    logic [IR_WIDTH-1:0] ir_active_d;
    logic [IR_WIDTH-1:0] ir_sr;
    dr_sel_e             dr_sel;

    always_comb begin
        if (ir_active_q == OP_IDCODE) begin
            dr_sel = DR_SEL_IDCODE;
        end else if (ir_active_q == OP_USER) begin
            dr_sel = DR_SEL_USER;
        end else begin
            dr_sel = DR_SEL_BYPASS;  // includes every undefined opcode
        end
    end

    logic sel_idcode;
    logic sel_user;
    logic sel_bypass;

    assign sel_idcode = (dr_sel == DR_SEL_IDCODE);
    assign sel_user   = (dr_sel == DR_SEL_USER);
    assign sel_bypass = (dr_sel == DR_SEL_BYPASS);

    // -------------------------------------------------------------------------
    // Instruction register shift stage
    // -------------------------------------------------------------------------
    jtag_shift_reg #(
        .WIDTH (IR_WIDTH)
    ) u_ir_sr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (bus.tap_reset),
        .load_i      (ir_cap),
        .load_data_i (IR_CAPTURE),
        .shift_i     (ir_shift),
        .sin_i       (bus.tdi),
        .data_o      (ir_sr)
    );

    always_comb begin
        ir_active_d = ir_active_q;
        if (bus.tap_reset) begin
            ir_active_d = OP_IDCODE;
        end else if (ir_upd) begin
            ir_active_d = ir_sr;
        end
    end

    // -------------------------------------------------------------------------
    // IDCODE data register
    // -------------------------------------------------------------------------
    logic [31:0] idcode_sr;

    jtag_shift_reg #(
        .WIDTH (32)
    ) u_idcode_sr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (bus.tap_reset),
        .load_i      (dr_cap & sel_idcode),
        .load_data_i (IDCODE_VALUE),
        .shift_i     (dr_shift & sel_idcode),
        .sin_i       (bus.tdi),
        .data_o      (idcode_sr)
    );

    // Only bit 0 of IDCODE is ever observed; the rest just ripples through.
    logic idcode_upper_unused;
    assign idcode_upper_unused = ^idcode_sr[31:1];

    // -------------------------------------------------------------------------
    // USER data register
    // -------------------------------------------------------------------------
    logic [USER_DR_WIDTH-1:0] user_sr;

    jtag_shift_reg #(
        .WIDTH (USER_DR_WIDTH)
    ) u_user_sr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (bus.tap_reset),
        .load_i      (dr_cap & sel_user),
        .load_data_i (bus.user_capture_data),
        .shift_i     (dr_shift & sel_user),
        .sin_i       (bus.tdi),
        .data_o      (user_sr)
    );

    // -------------------------------------------------------------------------
    // BYPASS flop, USER update register and its valid pulse
    // -------------------------------------------------------------------------
    logic                     bypass_q;
    logic                     bypass_d;
    logic [USER_DR_WIDTH-1:0] user_update_data_q;
    logic [USER_DR_WIDTH-1:0] user_update_data_d;
    logic                     user_update_valid_q;
    logic                     user_update_valid_d;
    logic                     user_commit;

    // tap_reset suppresses the commit; the held value survives TAP reset.
    assign user_commit = dr_upd & sel_user & ~bus.tap_reset;

    always_comb begin
        bypass_d = bypass_q;
        if (bus.tap_reset) begin
            bypass_d = 1'b0;
        end else if (dr_cap && sel_bypass) begin
            bypass_d = 1'b0;
        end else if (dr_shift && sel_bypass) begin
            bypass_d = bus.tdi;
        end
    end

    always_comb begin
        user_update_data_d  = user_update_data_q;
        user_update_valid_d = user_commit;
        if (user_commit) begin
            user_update_data_d = user_sr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_active_q         <= OP_IDCODE;
            bypass_q            <= 1'b0;
            user_update_data_q  <= '0;
            user_update_valid_q <= 1'b0;
        end else begin
            ir_active_q         <= ir_active_d;
            bypass_q            <= bypass_d;
            user_update_data_q  <= user_update_data_d;
            user_update_valid_q <= user_update_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // TDO selection (combinational, no added latency on the first shift bit)
    // -------------------------------------------------------------------------
    logic dr_tdo;
    logic tdo_d;

    always_comb begin
        unique case (dr_sel)
            DR_SEL_IDCODE: dr_tdo = idcode_sr[0];
            DR_SEL_USER:   dr_tdo = user_sr[0];
            default:       dr_tdo = bypass_q;
        endcase
    end

    always_comb begin
        tdo_d = 1'b0;
        if (bus.shift_ir) begin
            tdo_d = ir_sr[0];
        end else if (bus.shift_dr) begin
            tdo_d = dr_tdo;
        end
    end

    assign bus.tdo               = tdo_d;
    assign bus.tdo_en            = bus.shift_dr | bus.shift_ir;
    assign bus.ir_active         = ir_active_q;
    assign bus.user_update_data  = user_update_data_q;
    assign bus.user_update_valid = user_update_valid_q;

endmodule : jtag_scan_chain

// File: tb/tb_jtag_scan_chain.sv
// -----------------------------------------------------------------------------
// tb_jtag_scan_chain
// Directed plus randomized scans of the JTAG scan chain. The reference model
// treats each selected register as a FIFO of bits: capture fills it LSB first,
// each shift pops one bit to TDO and pushes TDI at the back; the FIFO content
// at update time is the committed value.
// -----------------------------------------------------------------------------
module tb_jtag_scan_chain;
    import jtag_pkg::*;

    localparam int          IRW = 5;
    localparam int          UW  = 32;
    localparam logic [31:0] IDV = 32'h1DEAD3FF;

    // Strobe vector order: {capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr}
    localparam logic [5:0] S_IDLE = 6'b000000;
    localparam logic [5:0] S_CIR  = 6'b100000;
    localparam logic [5:0] S_SIR  = 6'b010000;
    localparam logic [5:0] S_UIR  = 6'b001000;
    localparam logic [5:0] S_CDR  = 6'b000100;
    localparam logic [5:0] S_SDR  = 6'b000010;
    localparam logic [5:0] S_UDR  = 6'b000001;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jtag_scan_chain_if #(.IR_WIDTH(IRW), .USER_DR_WIDTH(UW)) bus ();

    jtag_scan_chain #(
        .IR_WIDTH      (IRW),
        .IDCODE_VALUE  (IDV),
        .USER_DR_WIDTH (UW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [IRW-1:0] m_ir;
    logic [UW-1:0]  m_user;
    logic [UW-1:0]  cap_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One TCK cycle: drive after the rising edge, return at the falling edge
    // so the caller samples mid-cycle.
    task automatic drive(input logic [5:0] s, input logic t, input logic trst);
        @(posedge clk);
        #1;
        {bus.capture_ir, bus.shift_ir, bus.update_ir,
         bus.capture_dr, bus.shift_dr, bus.update_dr} = s;
        bus.tdi       = t;
        bus.tap_reset = trst;
        @(negedge clk);
    endtask

    function automatic int dr_width(input logic [IRW-1:0] op);
        if (op == 5'h01) return 32;
        if (op == 5'h10) return UW;
        return 1;
    endfunction

    task automatic ir_scan(input logic [IRW-1:0] op, output logic [IRW-1:0] tdo_word);
        bit             fifo[$];
        logic [IRW-1:0] exp_word;
        int             en_cnt;
        en_cnt = 0;
        exp_word = '0;
        tdo_word = '0;
        for (int i = 0; i < IRW; i++) fifo.push_back(i == 0);  // ...00001
        drive(S_CIR, 1'b0, 1'b0);
        en_cnt += int'(bus.tdo_en);
        for (int i = 0; i < IRW; i++) begin
            drive(S_SIR, op[i], 1'b0);
            tdo_word[i] = bus.tdo;
            en_cnt += int'(bus.tdo_en);
            exp_word[i] = fifo.pop_front();
            fifo.push_back(op[i]);
        end
        drive(S_IDLE, 1'b0, 1'b0);
        en_cnt += int'(bus.tdo_en);
        drive(S_UIR, 1'b0, 1'b0);
        en_cnt += int'(bus.tdo_en);
        drive(S_IDLE, 1'b0, 1'b0);
        m_ir = op;
        check("ir_tdo", 64'(tdo_word), 64'(exp_word));
        check("ir_tdo_en_cycles", 64'(en_cnt), 64'(IRW));
        check("ir_active", 64'(bus.ir_active), 64'(m_ir));
        $display("IR scan op=%h tdo=%h ir_active=%h", op, tdo_word, bus.ir_active);
    endtask

    // pause_at: bit index before which an EXIT1/PAUSE/PAUSE/EXIT2 excursion is
    // inserted (values <= 0 or >= n mean no excursion).
    task automatic dr_scan(input int n, input logic [63:0] bits, input int pause_at,
                           input bit do_upd, output logic [63:0] tdo_word);
        bit          fifo[$];
        logic [63:0] cap;
        logic [63:0] exp_word;
        logic [UW-1:0] packed_q;
        int          w;
        int          en_cnt;
        logic        exp_valid;
        w = dr_width(m_ir);
        cap = (m_ir == 5'h01) ? 64'(IDV) : (m_ir == 5'h10) ? 64'(cap_data) : 64'd0;
        for (int i = 0; i < w; i++) fifo.push_back(cap[i]);
        en_cnt = 0;
        exp_word = '0;
        tdo_word = '0;
        drive(S_CDR, 1'b0, 1'b0);
        en_cnt += int'(bus.tdo_en);
        for (int i = 0; i < n; i++) begin
            if (i == pause_at && i > 0) begin
                for (int k = 0; k < 4; k++) begin
                    drive(S_IDLE, 1'b0, 1'b0);
                    en_cnt += int'(bus.tdo_en);
                end
            end
            drive(S_SDR, bits[i], 1'b0);
            tdo_word[i] = bus.tdo;
            en_cnt += int'(bus.tdo_en);
            exp_word[i] = fifo.pop_front();
            fifo.push_back(bits[i]);
        end
        drive(S_IDLE, 1'b0, 1'b0);
        en_cnt += int'(bus.tdo_en);
        check("dr_tdo", tdo_word, exp_word);
        check("dr_tdo_en_cycles", 64'(en_cnt), 64'(n));
        $display("DR scan ir=%h n=%0d tdi=%h tdo=%h", m_ir, n, bits, tdo_word);
        if (do_upd) begin
            drive(S_UDR, 1'b0, 1'b0);
            drive(S_IDLE, 1'b0, 1'b0);
            exp_valid = 1'b0;
            if (m_ir == 5'h10) begin
                packed_q = '0;
                for (int i = 0; i < UW; i++) packed_q[i] = fifo[i];
                m_user = packed_q;
                exp_valid = 1'b1;
            end
            check("upd_data", 64'(bus.user_update_data), 64'(m_user));
            check("upd_valid_pulse", 64'(bus.user_update_valid), 64'(exp_valid));
            drive(S_IDLE, 1'b0, 1'b0);
            check("upd_valid_drop", 64'(bus.user_update_valid), 64'd0);
            $display("DR update ir=%h user_update_data=%h", m_ir, bus.user_update_data);
        end
    endtask

    initial begin
        logic [63:0]    w;
        logic [IRW-1:0] iw;
        logic [IRW-1:0] op;
        int             n;
        int             pa;

        rst_n = 1'b0;
        {bus.capture_ir, bus.shift_ir, bus.update_ir,
         bus.capture_dr, bus.shift_dr, bus.update_dr} = S_IDLE;
        bus.tdi = 1'b0;
        bus.tap_reset = 1'b0;
        cap_data = '0;
        bus.user_capture_data = cap_data;
        m_ir = 5'h01;
        m_user = '0;

        repeat (2) @(negedge clk);
        check("rst_ir_active", 64'(bus.ir_active), 64'(5'h01));
        check("rst_tdo", 64'(bus.tdo), 64'd0);
        check("rst_tdo_en", 64'(bus.tdo_en), 64'd0);
        check("rst_user_data", 64'(bus.user_update_data), 64'd0);
        check("rst_user_valid", 64'(bus.user_update_valid), 64'd0);
        $display("Reset ir_active=%h tdo=%b tdo_en=%b", bus.ir_active, bus.tdo, bus.tdo_en);
        rst_n = 1'b1;

        // IDCODE straight out of reset
        dr_scan(32, 64'd0, -1, 1'b1, w);
        check("idcode_stream", 64'(w[31:0]), 64'(32'h1DEAD3FF));

        // IR capture pattern and BYPASS one-bit delay
        ir_scan(5'h1F, iw);
        check("ir_capture_pattern", 64'(iw), 64'(5'b00001));
        dr_scan(4, 64'b1101, -1, 1'b1, w);
        check("bypass_stream", 64'(w[3:0]), 64'(4'b1010));

        // USER capture/shift/update
        ir_scan(5'h10, iw);
        cap_data = 32'hCAFEF00D;
        bus.user_capture_data = cap_data;
        dr_scan(32, 64'(32'h12345678), -1, 1'b1, w);
        check("user_capture_stream", 64'(w[31:0]), 64'(32'hCAFEF00D));
        check("user_update_value", 64'(bus.user_update_data), 64'(32'h12345678));

        // Undefined opcode acts as BYPASS
        ir_scan(5'h07, iw);
        dr_scan(8, 64'($urandom_range(0, 255)), -1, 1'b1, w);

        // USER scan with a PAUSE excursion
        ir_scan(5'h10, iw);
        cap_data = $urandom;
        bus.user_capture_data = cap_data;
        dr_scan(32, 64'($urandom), 13, 1'b1, w);

        // TAP reset in the middle of a USER scan, coinciding with update_dr
        ir_scan(5'h10, iw);
        cap_data = $urandom;
        bus.user_capture_data = cap_data;
        dr_scan(10, 64'($urandom), -1, 1'b0, w);
        drive(S_UDR, 1'b0, 1'b1);
        m_ir = 5'h01;
        drive(S_IDLE, 1'b0, 1'b0);
        check("trst_ir_active", 64'(bus.ir_active), 64'(m_ir));
        check("trst_no_pulse", 64'(bus.user_update_valid), 64'd0);
        check("trst_user_hold", 64'(bus.user_update_data), 64'(m_user));
        $display("TAP reset ir_active=%h user_update_data=%h", bus.ir_active, bus.user_update_data);
        dr_scan(32, 64'd0, -1, 1'b1, w);
        check("trst_idcode_stream", 64'(w[31:0]), 64'(IDV));

        // Randomized scans
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 3))
                0:       op = 5'h01;
                1:       op = 5'h10;
                2:       op = 5'h1F;
                default: op = 5'($urandom);
            endcase
            ir_scan(op, iw);
            cap_data = $urandom;
            bus.user_capture_data = cap_data;
            n = $urandom_range(1, 48);
            pa = $urandom_range(0, n);
            dr_scan(n, {32'($urandom), 32'($urandom)}, pa, 1'b1, w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_jtag_scan_chain

// File: doc/jtag_scan_chain.md
# jtag_scan_chain

Instruction register, data registers (BYPASS, IDCODE, USER) and TDO selection for the JTAG port. Sits directly downstream of the TAP controller and consumes its `shift_dr`/`shift_ir`/`capture_*`/`update_*` strobes. It shifts TDI through the register selected by the active instruction and drives TDO. It presents a parallel USER data register to the debug logic behind it.

## Interface
Parameters:
- `IR_WIDTH`, 5: instruction register width.
- `IDCODE_VALUE`, 32'h1DEAD3FF: value captured by IDCODE; bit 0 must be 1.
- `USER_DR_WIDTH`, 32: width of the USER data register.

Ports:
- `clk`  in  1  TCK-domain clock; all state on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tdi`  in  1  serial data in.
- `shift_dr`, `shift_ir`, `capture_dr`, `capture_ir`, `update_dr`, `update_ir`  in  1 each  TAP controller strobes.
- `tap_reset`  in  1  high while TAP is in Test-Logic-Reset.
- `tdo`  out  1  serial data out.
- `tdo_en`  out  1  high when `tdo` is valid, i.e. `shift_dr | shift_ir`.
- `ir_active`  out  IR_WIDTH  currently latched instruction.
- `user_capture_data`  in  USER_DR_WIDTH  parallel value loaded on USER capture.
- `user_update_data`  out  USER_DR_WIDTH  last value committed by USER update.
- `user_update_valid`  out  1  one-cycle pulse when `user_update_data` changes.

## Operation
- Opcodes: IDCODE = 5'h01, USER = 5'h10, BYPASS = 5'h1F.
- Every undefined opcode selects BYPASS.
- Shift direction is LSB first.
  - On a shift cycle the selected shift register moves right by one.
  - `tdi` enters at the MSB; `tdo` is bit 0.
- IR path:
  - `capture_ir` loads the IR shift register with {0…, 2'b01}.
  - `shift_ir` shifts it.
  - `update_ir` copies it into `ir_active`.
- DR path, by `ir_active`:
  - BYPASS: 1-bit register. Capture loads 0; shift loads `tdi`.
  - IDCODE: 32-bit register. Capture loads `IDCODE_VALUE`; update has no effect.
  - USER: USER_DR_WIDTH register. Capture loads `user_capture_data`. Update copies the shift register to `user_update_data` and pulses `user_update_valid`.
- `tdo` is combinational:
  - `shift_ir` selects IR shift bit 0.
  - Otherwise, the selected DR bit 0.
  - It is 0 when `tdo_en` is low.
- `tap_reset` is synchronous and has highest priority:
  - `ir_active` goes to IDCODE; IR and DR shift registers clear.
  - `user_update_data` holds its value and no pulse is generated.
- Simultaneous strobes are illegal from the TAP controller. If they occur anyway, IR strobes win over DR strobes, and within a path capture > shift > update.
- `ir_active` changes only on `update_ir` or reset. A DR scan in progress therefore never switches register mid-scan.

## Timing
- Reset values: `ir_active` = IDCODE, all shift registers = 0, `user_update_data` = 0, `user_update_valid` = 0, `tdo` = 0, `tdo_en` = 0.
- Capture: the register holds the new value in the cycle after the `capture_*` strobe. The first shift cycle presents bit 0 on `tdo` with no extra latency.
- Shift: one bit per cycle while the strobe is high. A shift during EXIT2 (the strobe is high when the next state is SHIFT) is a normal shift.
- Update: `ir_active` and `user_update_data` change on the edge ending the update cycle. `user_update_valid` is high for exactly that following cycle.
- No path adds latency between the TAP strobe and the register action beyond one clock edge.

## Structure
- Shared package `jtag_pkg` holds:
  - `IR_WIDTH` default.
  - Opcode constants `JTAG_IR_IDCODE`, `JTAG_IR_USER`, `JTAG_IR_BYPASS`.
  - IR capture pattern constant.
- Sub-module `jtag_shift_reg`:
  - Parameterised width, parallel load, right shift with serial in, sync clear, async reset.
  - Instantiated for the IR, IDCODE and USER registers.
  - BYPASS is an inline flop.

## Test plan
- Reset, then a 32-bit DR scan with `tdi` = 0 → `tdo` stream = 32'h1DEAD3FF, LSB first; `tdo_en` high for exactly 32 cycles.
- IR scan of 5'h1F, then a DR scan shifting 1,0,1,1 → `tdo` returns 0,1,0,1 (one-bit delay).
- IR scan of 5'h10, capture with `user_capture_data` = 32'hCAFEF00D, shift in 32'h12345678 → `tdo` = 32'hCAFEF00D. After update: `user_update_data` = 32'h12345678 and `user_update_valid` is a single-cycle pulse.
- IR capture, then shift 5 bits → `tdo` = 1,0,0,0,0. An undefined opcode such as 5'h07 behaves as BYPASS.
- Assert `tap_reset` during a USER DR shift → `ir_active` = 5'h01, no update pulse, `user_update_data` unchanged.
- USER DR scan with a PAUSE/EXIT2 excursion → data integrity is preserved across the excursion.
